fetch_sequencer: RTL and testbench

- Control-side initiator for the 16-bit load/increment registers (PC, AR, IR) of the CPU datapath.
- Generates their ld/inr strobes and load data to run the instruction-fetch cycle: AR<-PC, read memory, IR<-M[AR] with PC+1, then hand IR to decode.
- Sits between the memory handshake and the decode/execute control unit.
- Supports jumps, halt and a memory timeout fault.

---
 rtl/fetch_sequencer_pkg.sv | 22 ++
 rtl/fetch_sequencer_if.sv | 53 +++++
 rtl/fetch_wait_timer.sv | 31 +++
 rtl/fetch_sequencer.sv | 84 ++++++++
 tb/tb_fetch_sequencer.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared CPU control package for the instruction-fetch sequencer.
// Contents:
//   CPU_ADDR_W    - datapath width of PC/AR/IR and their load-data buses
//   WAIT_MAX_DEF  - default T1 wait budget before a memory timeout fault
//   CNT_W_DEF     - default width of the completed-fetch counter
//   fetch_state_t - fetch sequencer state encoding
package fetch_sequencer_pkg;

    localparam int CPU_ADDR_W   = 16;
    localparam int WAIT_MAX_DEF = 15;
    localparam int CNT_W_DEF    = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_T0    = 3'd1,
        ST_T1    = 3'd2,
        ST_T2    = 3'd3,
        ST_HALT  = 3'd4,
        ST_FAULT = 3'd5
    } fetch_state_t;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Bundle of the fetch sequencer's control, memory-handshake, register-strobe
// and decode-handshake signals.
// Modports:
//   master - the fetch sequencer (drives strobes, mem_rd, ir_valid, status)
//   slave  - the surrounding datapath / memory / decode environment
// Signals:
//   run, halt_req                 - fetch enable and permanent-stop request
//   pc_q                          - current PC register value
//   mem_rd / mem_rdy              - memory read request / data valid
//   ar_ld, ar_ld_data             - AR load strobe and data
//   ir_ld                         - IR load strobe
//   pc_inr, pc_ld, pc_ld_data     - PC increment / load strobes and load data
//   ir_valid / decode_ack         - IR ready for decode / decode consumed it
//   jmp_req, jmp_addr             - jump redirect on the decode ack
//   busy, fault, fetch_cnt        - status outputs
interface fetch_sequencer_if
    import fetch_sequencer_pkg::*;
#(
    parameter int ADDR_W = CPU_ADDR_W,
    parameter int CNT_W  = CNT_W_DEF
);
    logic              run;
    logic              halt_req;
    logic [ADDR_W-1:0] pc_q;
    logic              mem_rd;
    logic              mem_rdy;
    logic              ar_ld;
    logic [ADDR_W-1:0] ar_ld_data;
    logic              ir_ld;
    logic              pc_inr;
    logic              pc_ld;
    logic [ADDR_W-1:0] pc_ld_data;
    logic              ir_valid;
    logic              decode_ack;
    logic              jmp_req;
    logic [ADDR_W-1:0] jmp_addr;
    logic              busy;
    logic              fault;
    logic [CNT_W-1:0]  fetch_cnt;

    modport master (
        input  run, halt_req, pc_q, mem_rdy, decode_ack, jmp_req, jmp_addr,
        output mem_rd, ar_ld, ar_ld_data, ir_ld, pc_inr, pc_ld, pc_ld_data,
               ir_valid, busy, fault, fetch_cnt
    );

    modport slave (
        output run, halt_req, pc_q, mem_rdy, decode_ack, jmp_req, jmp_addr,
        input  mem_rd, ar_ld, ar_ld_data, ir_ld, pc_inr, pc_ld, pc_ld_data,
               ir_valid, busy, fault, fetch_cnt
    );

endinterface

// File: rtl/fetch_wait_timer.sv
// Memory wait counter for the T1 state of the fetch sequencer.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   clear     - restart the count at zero (issued in T0)
//   en        - count one waited cycle (T1 without mem_rdy)
//   expired   - count has reached WAIT_MAX
module fetch_wait_timer #(
    parameter int WAIT_MAX = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic expired
);
    localparam int CW = $clog2(WAIT_MAX + 1);

    logic [CW-1:0] cnt;

    assign expired = (cnt == CW'(WAIT_MAX));

    // Holds at WAIT_MAX so the count can never wrap back to a small value.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (en && !expired) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: drives the PC/AR/IR ld/inr strobes to run
// AR<-PC, M[AR] read, IR<-M[AR] with PC+1, then hands IR to decode.
// Supports jump on decode ack, permanent halt and a sticky memory timeout.
// Ports:
//   clk, rst  - clock, synchronous active-high reset (dominates everything)
//   bus       - fetch_sequencer_if master modport (handshakes, strobes, status)
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int ADDR_W   = CPU_ADDR_W,
    parameter int WAIT_MAX = WAIT_MAX_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    fetch_sequencer_if.master bus
);
    fetch_state_t     state;
    logic [CNT_W-1:0] cnt;
    logic             in_t0;
    logic             in_t1;
    logic             in_t2;
    logic             wait_expired;

    assign in_t0 = (state == ST_T0);
    assign in_t1 = (state == ST_T1);
    assign in_t2 = (state == ST_T2);

    fetch_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_wait (
        .clk     (clk),
        .rst     (rst),
        .clear   (in_t0),
        .en      (in_t1 && !bus.mem_rdy),
        .expired (wait_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: if (bus.run) state <= ST_T0;
                ST_T0:   state <= ST_T1;
                ST_T1: begin
                    if (bus.mem_rdy) begin
                        state <= ST_T2;
                        cnt   <= cnt + CNT_W'(1);
                    end else if (wait_expired) begin
                        state <= ST_FAULT;
                    end
                end
                // Halt outranks stop; a jump on the same ack is still issued.
                ST_T2: begin
                    if (bus.decode_ack) begin
                        if (bus.halt_req)  state <= ST_HALT;
                        else if (!bus.run) state <= ST_IDLE;
                        else               state <= ST_T0;
                    end
                end
                ST_HALT:  state <= ST_HALT;
                ST_FAULT: state <= ST_FAULT;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    // Moore outputs decoded from the state register.
    assign bus.ar_ld    = in_t0;
    assign bus.mem_rd   = in_t1;
    assign bus.ir_valid = in_t2;
    assign bus.busy     = in_t0 || in_t1 || in_t2;
    assign bus.fault    = (state == ST_FAULT);

    // Same-cycle strobes; masked by rst so a reset cycle never touches PC/IR.
    assign bus.ir_ld  = in_t1 && bus.mem_rdy && !rst;
    assign bus.pc_inr = in_t1 && bus.mem_rdy && !rst;
    assign bus.pc_ld  = in_t2 && bus.decode_ack && bus.jmp_req && !rst;

    assign bus.ar_ld_data = ADDR_W'(bus.pc_q);
    assign bus.pc_ld_data = ADDR_W'(bus.jmp_addr);
    assign bus.fetch_cnt  = cnt;

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;
    import fetch_sequencer_pkg::*;

    localparam int AW = 16;
    localparam int WM = 15;
    localparam int CW = 10;

    // outs = {ar_ld, mem_rd, ir_ld, pc_inr, pc_ld, ir_valid, busy, fault}
    localparam logic [7:0] O_IDLE  = 8'b0000_0000;
    localparam logic [7:0] O_T0    = 8'b1000_0010;
    localparam logic [7:0] O_T1    = 8'b0100_0010;
    localparam logic [7:0] O_T1R   = 8'b0111_0010;
    localparam logic [7:0] O_T2    = 8'b0000_0110;
    localparam logic [7:0] O_T2J   = 8'b0000_1110;
    localparam logic [7:0] O_FAULT = 8'b0000_0001;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_sequencer_if #(.ADDR_W(AW), .CNT_W(CW)) bus ();

    fetch_sequencer #(.ADDR_W(AW), .WAIT_MAX(WM), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [7:0] outs;
    assign outs = {bus.ar_ld, bus.mem_rd, bus.ir_ld, bus.pc_inr,
                   bus.pc_ld, bus.ir_valid, bus.busy, bus.fault};

    int checks = 0;
    int errors = 0;

    logic [AW-1:0] ar_sb[$];
    logic [AW-1:0] pc_sb[$];
    logic [CW-1:0] cnt_sb[$];
    logic [CW-1:0] exp_cnt;
    logic [AW-1:0] exp_a;
    logic [CW-1:0] exp_c;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        bus.run = 1'b0; bus.halt_req = 1'b0; bus.mem_rdy = 1'b0;
        bus.decode_ack = 1'b0; bus.jmp_req = 1'b0; bus.jmp_addr = '0; bus.pc_q = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_cnt = '0;
        ar_sb.delete(); pc_sb.delete(); cnt_sb.delete();
        #1;
    endtask

    task automatic test_reset;
        do_reset;
        checks++; if (outs !== O_IDLE) begin errors++; $display("FAIL reset_outs got %b want %b", outs, O_IDLE); end
        checks++; if (bus.fetch_cnt !== '0) begin errors++; $display("FAIL reset_cnt got %0h want 0", bus.fetch_cnt); end
        bus.mem_rdy = 1'b1; bus.decode_ack = 1'b1; bus.jmp_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            checks++; if (outs !== O_IDLE) begin errors++; $display("FAIL reset_idle_hold got %b want %b", outs, O_IDLE); end
        end
        bus.mem_rdy = 1'b0; bus.decode_ack = 1'b0; bus.jmp_req = 1'b0;
    endtask

    task automatic test_basic;
        bus.pc_q = 16'h0010; bus.run = 1'b1; bus.mem_rdy = 1'b1; bus.decode_ack = 1'b1;
        ar_sb.push_back(16'h0010);
        tick;  // cycle 1: T0
        checks++; if (outs !== O_T0) begin errors++; $display("FAIL basic_c1 got %b want %b", outs, O_T0); end
        exp_a = (ar_sb.size() > 0) ? ar_sb.pop_front() : 'x;
        checks++; if (bus.ar_ld_data !== exp_a) begin errors++; $display("FAIL basic_ar_data got %0h want %0h", bus.ar_ld_data, exp_a); end
        tick;  // cycle 2: T1 with mem_rdy
        checks++; if (outs !== O_T1R) begin errors++; $display("FAIL basic_c2 got %b want %b", outs, O_T1R); end
        exp_cnt = exp_cnt + 1'b1; cnt_sb.push_back(exp_cnt);
        tick;  // cycle 3: T2 with ack
        checks++; if (outs !== O_T2) begin errors++; $display("FAIL basic_c3 got %b want %b", outs, O_T2); end
        exp_c = (cnt_sb.size() > 0) ? cnt_sb.pop_front() : 'x;
        checks++; if (bus.fetch_cnt !== exp_c) begin errors++; $display("FAIL basic_cnt got %0h want %0h", bus.fetch_cnt, exp_c); end
        ar_sb.push_back(16'h0010);
        tick;  // cycle 4: back in T0
        checks++; if (outs !== O_T0) begin errors++; $display("FAIL basic_c4 got %b want %b", outs, O_T0); end
        exp_a = (ar_sb.size() > 0) ? ar_sb.pop_front() : 'x;
        checks++; if (bus.ar_ld_data !== exp_a) begin errors++; $display("FAIL basic_ar_data2 got %0h want %0h", bus.ar_ld_data, exp_a); end
        checks++; if (bus.fetch_cnt !== 10'd1) begin errors++; $display("FAIL basic_cnt_c4 got %0h want 1", bus.fetch_cnt); end
        bus.run = 1'b0;
        tick;  // T1: in-flight fetch completes despite run=0
        checks++; if (outs !== O_T1R) begin errors++; $display("FAIL basic_inflight got %b want %b", outs, O_T1R); end
        exp_cnt = exp_cnt + 1'b1; cnt_sb.push_back(exp_cnt);
        tick;  // T2 ack with run=0
        exp_c = (cnt_sb.size() > 0) ? cnt_sb.pop_front() : 'x;
        checks++; if (bus.fetch_cnt !== exp_c) begin errors++; $display("FAIL basic_cnt2 got %0h want %0h", bus.fetch_cnt, exp_c); end
        tick;
        checks++; if (outs !== O_IDLE) begin errors++; $display("FAIL basic_idle got %b want %b", outs, O_IDLE); end
        bus.mem_rdy = 1'b0; bus.decode_ack = 1'b0;
    endtask

    task automatic test_mem_wait;
        int n_rd;
        int n_ld;
        n_rd = 0; n_ld = 0;
        bus.pc_q = 16'h0200; bus.run = 1'b1; bus.mem_rdy = 1'b0; bus.decode_ack = 1'b0;
        ar_sb.push_back(16'h0200);
        tick;
        checks++; if (outs !== O_T0) begin errors++; $display("FAIL wait_t0 got %b want %b", outs, O_T0); end
        exp_a = (ar_sb.size() > 0) ? ar_sb.pop_front() : 'x;
        checks++; if (bus.ar_ld_data !== exp_a) begin errors++; $display("FAIL wait_ar_data got %0h want %0h", bus.ar_ld_data, exp_a); end
        for (int c = 0; c < 6; c++) begin
            tick;
            bus.mem_rdy = (c == 5);
            #1;
            n_rd += int'(bus.mem_rd);
            n_ld += int'(bus.ir_ld);
            checks++; if (outs !== ((c == 5) ? O_T1R : O_T1)) begin errors++; $display("FAIL wait_t1_%0d got %b want %b", c, outs, (c == 5) ? O_T1R : O_T1); end
        end
        exp_cnt = exp_cnt + 1'b1; cnt_sb.push_back(exp_cnt);
        checks++; if (n_rd != 6) begin errors++; $display("FAIL wait_mem_rd_cycles got %0d want 6", n_rd); end
        checks++; if (n_ld != 1) begin errors++; $display("FAIL wait_ir_ld_count got %0d want 1", n_ld); end
        tick;
        bus.mem_rdy = 1'b0;
        #1;
        checks++; if (outs !== O_T2) begin errors++; $display("FAIL wait_t2 got %b want %b", outs, O_T2); end
        exp_c = (cnt_sb.size() > 0) ? cnt_sb.pop_front() : 'x;
        checks++; if (bus.fetch_cnt !== exp_c) begin errors++; $display("FAIL wait_cnt got %0h want %0h", bus.fetch_cnt, exp_c); end
        bus.run = 1'b0; bus.decode_ack = 1'b1;
        tick;
        checks++; if (outs !== O_IDLE) begin errors++; $display("FAIL wait_idle got %b want %b", outs, O_IDLE); end
        bus.decode_ack = 1'b0;
    endtask

    task automatic test_timeout;
        bus.pc_q = 16'h0300; bus.run = 1'b1; bus.mem_rdy = 1'b0;
        tick;
        checks++; if (outs !== O_T0) begin errors++; $display("FAIL tmo_t0 got %b want %b", outs, O_T0); end
        for (int c = 0; c <= WM; c++) begin
            tick;
            checks++; if (outs !== O_T1) begin errors++; $display("FAIL tmo_t1_%0d got %b want %b", c, outs, O_T1); end
        end
        tick;
        checks++; if (outs !== O_FAULT) begin errors++; $display("FAIL tmo_fault got %b want %b", outs, O_FAULT); end
        for (int c = 0; c < 10; c++) begin
            bus.run = c[0]; bus.mem_rdy = ~c[0]; bus.decode_ack = c[0];
            tick;
            checks++; if (outs !== O_FAULT) begin errors++; $display("FAIL tmo_sticky_%0d got %b want %b", c, outs, O_FAULT); end
        end
        do_reset;
        checks++; if (outs !== O_IDLE) begin errors++; $display("FAIL tmo_reset got %b want %b", outs, O_IDLE); end
    endtask

    task automatic test_jump_halt;
        int n_ar;
        n_ar = 0;
        bus.pc_q = 16'h0040; bus.run = 1'b1; bus.mem_rdy = 1'b1;
        bus.jmp_req = 1'b1; bus.jmp_addr = 16'h0ABC;
        tick;
        checks++; if (outs !== O_T0) begin errors++; $display("FAIL jh_t0 got %b want %b", outs, O_T0); end
        tick;
        checks++; if (outs !== O_T1R) begin errors++; $display("FAIL jh_t1 got %b want %b", outs, O_T1R); end
        exp_cnt = exp_cnt + 1'b1; cnt_sb.push_back(exp_cnt);
        tick;
        bus.mem_rdy = 1'b0;
        #1;
        checks++; if (outs !== O_T2) begin errors++; $display("FAIL jh_t2_noack got %b want %b", outs, O_T2); end
        exp_c = (cnt_sb.size() > 0) ? cnt_sb.pop_front() : 'x;
        checks++; if (bus.fetch_cnt !== exp_c) begin errors++; $display("FAIL jh_cnt got %0h want %0h", bus.fetch_cnt, exp_c); end
        bus.decode_ack = 1'b1; bus.halt_req = 1'b1;
        pc_sb.push_back(16'h0ABC);
        #1;
        checks++; if (outs !== O_T2J) begin errors++; $display("FAIL jh_ack got %b want %b", outs, O_T2J); end
        exp_a = (pc_sb.size() > 0) ? pc_sb.pop_front() : 'x;
        checks++; if (bus.pc_ld_data !== exp_a) begin errors++; $display("FAIL jh_pc_data got %0h want %0h", bus.pc_ld_data, exp_a); end
        tick;
        bus.halt_req = 1'b0;
        for (int c = 0; c < 20; c++) begin
            #1;
            n_ar += int'(bus.ar_ld);
            checks++; if (outs !== O_IDLE) begin errors++; $display("FAIL jh_halt_%0d got %b want %b", c, outs, O_IDLE); end
            bus.mem_rdy = c[0]; bus.decode_ack = ~c[0];
            tick;
        end
        checks++; if (n_ar != 0) begin errors++; $display("FAIL jh_ar_after_halt got %0d want 0", n_ar); end
        do_reset;
    endtask

    task automatic test_reset_mid;
        bus.pc_q = 16'h0500; bus.run = 1'b1; bus.mem_rdy = 1'b1; bus.decode_ack = 1'b1;
        tick;
        tick;
        exp_cnt = exp_cnt + 1'b1; cnt_sb.push_back(exp_cnt);
        tick;
        exp_c = (cnt_sb.size() > 0) ? cnt_sb.pop_front() : 'x;
        checks++; if (bus.fetch_cnt !== exp_c) begin errors++; $display("FAIL rmid_cnt_pre got %0h want %0h", bus.fetch_cnt, exp_c); end
        bus.mem_rdy = 1'b0;
        tick;  // T0
        tick;  // T1 waiting
        checks++; if (outs !== O_T1) begin errors++; $display("FAIL rmid_t1 got %b want %b", outs, O_T1); end
        rst = 1'b1; bus.run = 1'b0;
        tick;
        rst = 1'b0; bus.mem_rdy = 1'b1;
        exp_cnt = '0;
        #1;
        checks++; if (outs !== O_IDLE) begin errors++; $display("FAIL rmid_outs got %b want %b", outs, O_IDLE); end
        checks++; if (bus.fetch_cnt !== exp_cnt) begin errors++; $display("FAIL rmid_cnt got %0h want %0h", bus.fetch_cnt, exp_cnt); end
        for (int c = 0; c < 3; c++) begin
            tick;
            checks++; if (bus.ir_ld !== 1'b0) begin errors++; $display("FAIL rmid_late_rdy got %b want 0", bus.ir_ld); end
        end
        bus.mem_rdy = 1'b0; bus.decode_ack = 1'b0;
    endtask

    task automatic test_stop;
        bus.pc_q = 16'h0600; bus.run = 1'b1; bus.mem_rdy = 1'b1; bus.decode_ack = 1'b1;
        tick;
        tick;
        exp_cnt = exp_cnt + 1'b1; cnt_sb.push_back(exp_cnt);
        tick;
        bus.run = 1'b0;
        #1;
        checks++; if (outs !== O_T2) begin errors++; $display("FAIL stop_t2 got %b want %b", outs, O_T2); end
        exp_c = (cnt_sb.size() > 0) ? cnt_sb.pop_front() : 'x;
        checks++; if (bus.fetch_cnt !== exp_c) begin errors++; $display("FAIL stop_cnt got %0h want %0h", bus.fetch_cnt, exp_c); end
        for (int c = 0; c < 4; c++) begin
            tick;
            checks++; if (outs !== O_IDLE) begin errors++; $display("FAIL stop_idle_%0d got %b want %b", c, outs, O_IDLE); end
        end
        bus.run = 1'b1; bus.pc_q = 16'h0700;
        ar_sb.push_back(16'h0700);
        tick;
        checks++; if (outs !== O_T0) begin errors++; $display("FAIL stop_resume got %b want %b", outs, O_T0); end
        exp_a = (ar_sb.size() > 0) ? ar_sb.pop_front() : 'x;
        checks++; if (bus.ar_ld_data !== exp_a) begin errors++; $display("FAIL stop_ar_data got %0h want %0h", bus.ar_ld_data, exp_a); end
        bus.run = 1'b0;
        tick;
        exp_cnt = exp_cnt + 1'b1;
        tick;
        tick;
        checks++; if (outs !== O_IDLE) begin errors++; $display("FAIL stop_end got %b want %b", outs, O_IDLE); end
        bus.mem_rdy = 1'b0; bus.decode_ack = 1'b0;
    endtask

    task automatic test_wrap;
        bit saw_wrap;
        int budget;
        saw_wrap = 1'b0;
        budget = 4 * (1 << CW) + 16;
        bus.pc_q = 16'h0800; bus.run = 1'b1; bus.mem_rdy = 1'b1; bus.decode_ack = 1'b1;
        while (!saw_wrap && budget > 0) begin
            tick;
            budget--;
            if (bus.mem_rd) begin
                exp_cnt = exp_cnt + 1'b1;
                cnt_sb.push_back(exp_cnt);
            end
            if (bus.ir_valid) begin
                exp_c = (cnt_sb.size() > 0) ? cnt_sb.pop_front() : 'x;
                checks++; if (bus.fetch_cnt !== exp_c) begin errors++; $display("FAIL wrap_cnt got %0h want %0h", bus.fetch_cnt, exp_c); end
                if (exp_c == '0) begin
                    saw_wrap = 1'b1;
                    bus.run = 1'b0;
                end
            end
        end
        checks++; if (!saw_wrap) begin errors++; $display("FAIL wrap_timeout got %0d want 1", saw_wrap); end
        tick;
        checks++; if (outs !== O_IDLE) begin errors++; $display("FAIL wrap_idle got %b want %b", outs, O_IDLE); end
        checks++; if (bus.fetch_cnt !== '0) begin errors++; $display("FAIL wrap_zero got %0h want 0", bus.fetch_cnt); end
        bus.mem_rdy = 1'b0; bus.decode_ack = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

    initial begin
        exp_cnt = '0;
        test_reset;
        test_basic;
        test_mem_wait;
        test_timeout;
        test_jump_halt;
        test_reset_mid;
        test_stop;
        test_wrap;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
